// File: rtl/rv32i_types.sv
// rv32i_types: shared store-queue entry, store funct3 encodings and drain FSM states.
package rv32i_types;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct3;
    } sb_entry_t;
    typedef enum logic [2:0] {SB = 3'b000, SH = 3'b001, SW = 3'b010} store_funct3_t;
    typedef enum logic {IDLE, WRITE} drain_state_t;
endpackage

// File: rtl/store_drain_unit_align.sv
// store_lane_align: byte-lane mask, replicated write data and alignment check for one store.
module store_lane_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic        misaligned
);
    always_comb begin
        wmask      = funct3 == SW ? 4'b1111 : (funct3 == SH ? 4'b0011 : 4'b0001) << addr_lo;
        wdata      = funct3 == SW ? data : funct3 == SH ? {2{data[15:0]}} : {4{data[7:0]}};
        misaligned = funct3 == SH ? addr_lo[0] : funct3 == SW ? |addr_lo : funct3 != SB;
    end
endmodule

// File: rtl/store_drain_unit.sv
// store_drain_unit: pops committed stores and issues them as held, byte-masked word writes.
module store_drain_unit
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  sb_entry_t        sq_entry,
    input  logic             sq_empty,
    output logic             sq_deq,
    input  logic             drain_en,
    output logic [31:0]      dmem_addr,
    output logic [3:0]       dmem_wmask,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_resp,
    input  logic [31:0]      ld_addr,
    output logic             ld_conflict,
    output logic             busy,
    output logic             err_misaligned,
    output logic [CNT_W-1:0] drained_cnt
);
    drain_state_t state, state_d;
    logic [3:0]   al_mask;
    logic [31:0]  al_data;
    logic         al_mis;
    logic         launch;

    store_lane_align u_align (
        .funct3    (sq_entry.funct3),
        .addr_lo   (sq_entry.addr[1:0]),
        .data      (sq_entry.data),
        .wmask     (al_mask),
        .wdata     (al_data),
        .misaligned(al_mis)
    );

    // The pop is combinational so the entry is latched on the same edge it leaves the queue.
    assign busy        = state != IDLE;
    assign sq_deq      = rst_n && !busy && !sq_empty && drain_en;
    assign launch      = sq_deq && sq_entry.valid && !al_mis;
    assign ld_conflict = busy && ((ld_addr | 32'h3) == (dmem_addr | 32'h3));

    always_comb begin
        state_d = busy ? (dmem_resp ? IDLE : WRITE) : (launch ? WRITE : IDLE);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_addr      <= '0;
            dmem_wmask     <= '0;
            dmem_wdata     <= '0;
            err_misaligned <= 1'b0;
            drained_cnt    <= '0;
        end else begin
            err_misaligned <= sq_deq && sq_entry.valid && al_mis;
            if (launch) begin
                dmem_addr  <= {sq_entry.addr[31:2], 2'b00};
                dmem_wmask <= al_mask;
                dmem_wdata <= al_data;
            end else if (busy && dmem_resp) begin
                dmem_wmask  <= '0;
                drained_cnt <= drained_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_store_drain_unit.sv
// tb_store_drain_unit: directed scenarios for store_drain_unit with hand-computed expectations.
module tb_store_drain_unit;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst_n;
    sb_entry_t   sq_entry;
    logic        sq_empty;
    logic        sq_deq;
    logic        drain_en;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        busy;
    logic        err_misaligned;
    logic [31:0] drained_cnt;
    int          checks = 0;
    int          errors = 0;

    store_drain_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .sq_entry(sq_entry), .sq_empty(sq_empty), .sq_deq(sq_deq),
        .drain_en(drain_en), .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .ld_addr(ld_addr),
        .ld_conflict(ld_conflict), .busy(busy), .err_misaligned(err_misaligned),
        .drained_cnt(drained_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_entry(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        sq_entry.valid  = v;
        sq_entry.addr   = a;
        sq_entry.data   = d;
        sq_entry.funct3 = f;
        sq_empty        = 1'b0;
        drain_en        = 1'b1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        dmem_resp = 1'b0;
        ld_addr   = 32'h0;
        set_entry(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 3'b010);
        #3;
        checks++;
        if ({sq_deq, busy, err_misaligned, ld_conflict} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {sq_deq, busy, err_misaligned, ld_conflict});
        end
        checks++;
        if (dmem_wmask !== 4'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || drained_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs got mask %h addr %h data %h cnt %0d want zeros", dmem_wmask, dmem_addr, dmem_wdata, drained_cnt);
        end
        tick;
        sq_empty = 1'b1;
        rst_n    = 1'b1;
        tick;
    endtask

    task automatic test_sw;
        set_entry(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 3'b010);
        #1;
        checks++;
        if (sq_deq !== 1'b1 || dmem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL sw_pop got deq %b mask %h want 1 0", sq_deq, dmem_wmask);
        end
        tick;
        sq_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (sq_deq !== 1'b0 || busy !== 1'b1 || dmem_addr !== 32'h1000_0004 || dmem_wmask !== 4'hF || dmem_wdata !== 32'hDEAD_BEEF || drained_cnt !== 32'd0) begin
                errors++;
                $display("FAIL sw_req cyc %0d got deq %b busy %b addr %h mask %h data %h cnt %0d want 0 1 10000004 f deadbeef 0", i, sq_deq, busy, dmem_addr, dmem_wmask, dmem_wdata, drained_cnt);
            end
            tick;
        end
        dmem_resp = 1'b1;
        tick;
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (dmem_wmask !== 4'h0 || busy !== 1'b0 || drained_cnt !== 32'd1) begin
            errors++;
            $display("FAIL sw_done got mask %h busy %b cnt %0d want 0 0 1", dmem_wmask, busy, drained_cnt);
        end
    endtask

    task automatic test_sb;
        set_entry(1'b1, 32'h1000_0003, 32'h0000_00AB, 3'b000);
        tick;
        sq_empty = 1'b1;
        #1;
        checks++;
        if (dmem_addr !== 32'h1000_0000 || dmem_wmask !== 4'b1000 || dmem_wdata !== 32'hABAB_ABAB) begin
            errors++;
            $display("FAIL sb_req got addr %h mask %b data %h want 10000000 1000 abababab", dmem_addr, dmem_wmask, dmem_wdata);
        end
        dmem_resp = 1'b1;
        tick;
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (drained_cnt !== 32'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_done got cnt %0d busy %b want 2 0", drained_cnt, busy);
        end
    endtask

    task automatic test_sh_hold;
        set_entry(1'b1, 32'h2000_0002, 32'h0000_1234, 3'b001);
        tick;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) drain_en = 1'b0;
            #1;
            checks++;
            if (sq_deq !== 1'b0 || dmem_addr !== 32'h2000_0000 || dmem_wmask !== 4'b1100 || dmem_wdata !== 32'h1234_1234) begin
                errors++;
                $display("FAIL sh_hold cyc %0d got deq %b addr %h mask %b data %h want 0 20000000 1100 12341234", i, sq_deq, dmem_addr, dmem_wmask, dmem_wdata);
            end
            tick;
        end
        dmem_resp = 1'b1;
        sq_empty  = 1'b1;
        tick;
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (drained_cnt !== 32'd3 || dmem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL sh_done got cnt %0d mask %h want 3 0", drained_cnt, dmem_wmask);
        end
    endtask

    task automatic test_misaligned;
        logic [2:0] f3 [3] = '{3'b001, 3'b010, 3'b011};
        logic [31:0] ad [3] = '{32'h2000_0001, 32'h2000_0002, 32'h2000_0000};
        for (int i = 0; i < 3; i++) begin
            set_entry(1'b1, ad[i], 32'h5555_AAAA, f3[i]);
            #1;
            checks++;
            if (sq_deq !== 1'b1) begin
                errors++;
                $display("FAIL mis_pop %0d got deq %b want 1", i, sq_deq);
            end
            tick;
            sq_empty = 1'b1;
            #1;
            checks++;
            if (err_misaligned !== 1'b1 || dmem_wmask !== 4'h0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mis_err %0d got err %b mask %h busy %b want 1 0 0", i, err_misaligned, dmem_wmask, busy);
            end
            tick;
            checks++;
            if (err_misaligned !== 1'b0 || drained_cnt !== 32'd3) begin
                errors++;
                $display("FAIL mis_after %0d got err %b cnt %0d want 0 3", i, err_misaligned, drained_cnt);
            end
        end
        set_entry(1'b0, 32'h2000_0000, 32'h1, 3'b010);
        #1;
        checks++;
        if (sq_deq !== 1'b1) begin
            errors++;
            $display("FAIL invalid_pop got deq %b want 1", sq_deq);
        end
        tick;
        sq_empty = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || err_misaligned !== 1'b0 || dmem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL invalid_drop got busy %b err %b mask %h want 0 0 0", busy, err_misaligned, dmem_wmask);
        end
    endtask

    task automatic test_resp_idle;
        dmem_resp = 1'b1;
        tick;
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || drained_cnt !== 32'd3 || dmem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL resp_idle got busy %b cnt %0d mask %h want 0 3 0", busy, drained_cnt, dmem_wmask);
        end
    endtask

    task automatic test_drain_gate;
        set_entry(1'b1, 32'h3000_0008, 32'hCAFE_F00D, 3'b010);
        drain_en = 1'b0;
        ld_addr  = 32'h3000_0008;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (sq_deq !== 1'b0 || busy !== 1'b0 || ld_conflict !== 1'b0) begin
                errors++;
                $display("FAIL gate cyc %0d got deq %b busy %b conf %b want 0 0 0", i, sq_deq, busy, ld_conflict);
            end
            tick;
        end
        drain_en = 1'b1;
        tick;
        sq_empty = 1'b1;
        ld_addr  = 32'h3000_000A;
        #1;
        checks++;
        if (busy !== 1'b1 || ld_conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_hit got busy %b conf %b want 1 1", busy, ld_conflict);
        end
        ld_addr = 32'h3000_000C;
        #1;
        checks++;
        if (ld_conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_miss got %b want 0", ld_conflict);
        end
        ld_addr = 32'h3000_0008;
    endtask

    task automatic test_reset_mid_write;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_wmask !== 4'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || busy !== 1'b0 || ld_conflict !== 1'b0 || drained_cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got mask %h addr %h data %h busy %b conf %b cnt %0d want zeros", dmem_wmask, dmem_addr, dmem_wdata, busy, ld_conflict, drained_cnt);
        end
        tick;
        rst_n = 1'b1;
        set_entry(1'b1, 32'h4000_0000, 32'h1122_3344, 3'b010);
        tick;
        sq_empty = 1'b1;
        #1;
        checks++;
        if (dmem_addr !== 32'h4000_0000 || dmem_wmask !== 4'hF || dmem_wdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL post_reset_req got addr %h mask %h data %h want 40000000 f 11223344", dmem_addr, dmem_wmask, dmem_wdata);
        end
        dmem_resp = 1'b1;
        tick;
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (drained_cnt !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_done got cnt %0d busy %b want 1 0", drained_cnt, busy);
        end
    endtask

    task automatic test_back_to_back;
        set_entry(1'b1, 32'h5000_0000, 32'h0000_0001, 3'b010);
        tick;
        set_entry(1'b1, 32'h5000_0001, 32'h0000_0077, 3'b000);
        #1;
        checks++;
        if (sq_deq !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write got deq %b busy %b want 0 1", sq_deq, busy);
        end
        dmem_resp = 1'b1;
        tick;
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (sq_deq !== 1'b1 || busy !== 1'b0 || drained_cnt !== 32'd2) begin
            errors++;
            $display("FAIL b2b_idle got deq %b busy %b cnt %0d want 1 0 2", sq_deq, busy, drained_cnt);
        end
        tick;
        sq_empty = 1'b1;
        #1;
        checks++;
        if (dmem_addr !== 32'h5000_0000 || dmem_wmask !== 4'b0010 || dmem_wdata !== 32'h7777_7777) begin
            errors++;
            $display("FAIL b2b_second got addr %h mask %b data %h want 50000000 0010 77777777", dmem_addr, dmem_wmask, dmem_wdata);
        end
        dmem_resp = 1'b1;
        tick;
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (drained_cnt !== 32'd3 || dmem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL b2b_done got cnt %0d mask %h want 3 0", drained_cnt, dmem_wmask);
        end
    endtask

    initial begin
        test_reset;
        test_sw;
        test_sb;
        test_sh_hold;
        test_misaligned;
        test_resp_idle;
        test_drain_gate;
        test_reset_mid_write;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
